// File: rtl/arith_pipe_hs.sv
// Elastic arithmetic pipeline: stage 0 adds a constant and each later stage
// multiplies by an alternating constant, with per-stage valid/ready handshake.

module arith_pipe_hs_stage #(
  parameter int W      = 4,
  parameter int IS_ADD = 0,
  parameter int C      = 1
) (
  input  logic [W-1:0] op_i,
  input  logic         sat_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);
  // 32 guard bits keep any int constant product exact before reduction
  localparam int FW = W + 32;

  logic [FW-1:0] full;

  always_comb begin
    if (IS_ADD != 0) full = FW'(op_i) + FW'(C);
    else             full = FW'(op_i) * FW'(C);
  end

  assign ovf_o = |full[FW-1:W];
  assign res_o = (ovf_o && sat_i) ? {W{1'b1}} : full[W-1:0];
endmodule

module arith_pipe_hs #(
  parameter int W        = 4,
  parameter int IN_W     = 2,
  parameter int DEPTH    = 4,
  parameter int ADD_C    = 1,
  parameter int MUL_ODD  = 2,
  parameter int MUL_EVEN = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [W-1:0]                 out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         sat_en,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] data_q, data_d, res, op;
  logic [DEPTH-1:0]        vld_q, vld_d, load, st_ovf;
  logic [DEPTH:0]          rdy;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    in_xfer, out_xfer;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign op[k]   = W'(in_data);
        assign load[k] = in_xfer;
      end else begin : g_rest
        assign op[k]   = data_q[k-1];
        assign load[k] = rdy[k] & vld_q[k-1];
      end
      // a stage is free if empty or its occupant moves on this cycle
      assign rdy[k] = ~vld_q[k] | rdy[k+1];

      arith_pipe_hs_stage #(
        .W      (W),
        .IS_ADD ((k == 0) ? 1 : 0),
        .C      ((k == 0) ? ADD_C : ((k % 2 == 1) ? MUL_ODD : MUL_EVEN))
      ) u_stage (
        .op_i  (op[k]),
        .sat_i (sat_en),
        .res_o (res[k]),
        .ovf_o (st_ovf[k])
      );
    end
  endgenerate

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] & ~flush & rst_n;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = vld_q[DEPTH-1] & out_ready;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (|(load & st_ovf));
    for (int i = 0; i < DEPTH; i++) begin
      if (load[i]) begin
        vld_d[i]  = 1'b1;
        data_d[i] = res[i];
      end else if (rdy[i]) begin
        vld_d[i]  = 1'b0;
      end
    end
    if (in_xfer && !out_xfer)      cnt_d = cnt_q + 1'b1;
    else if (!in_xfer && out_xfer) cnt_d = cnt_q - 1'b1;
    if (flush) begin
      vld_d  = '0;
      data_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = cnt_q;
  assign ovf       = ovf_q;
endmodule
